// File: rtl/dimm_burst_sequencer.sv
// dimm_burst_sequencer: schedules decoded RD/RDA/WR/WRA column commands
// at CL/CWL into a slot pool, then drives one registered beat per clock.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   RD, RDA, WR, WRA           one-hot decoded command pulses
//   cs_n[RANKS]                active-low rank selects
//   bg, ba, A[16:0]            bank group, bank, address (col, A12 = BL8)
//   dq_oe / dq_we              read / write beat active
//   beat_col/rank/bg/ba        address of the current beat
//   beat_last, dqs_t, ap_done  last beat, beat strobe, auto-precharge done
//   qfull, busy                slot pool full, any activity
//   cs_err, ovf_err, ovl_err   one-cycle error pulses
module dimm_burst_sequencer #(
    parameter int RANKS      = 1,
    parameter int BGWIDTH    = 2,
    parameter int BAWIDTH    = 2,
    parameter int COLWIDTH   = 10,
    parameter int CL         = 5,
    parameter int CWL        = 4,
    parameter int BURST_MODE = 0,
    parameter int SLOTS      = 4,
    localparam int RKW       = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RD,
    input  logic                RDA,
    input  logic                WR,
    input  logic                WRA,
    input  logic [RANKS-1:0]    cs_n,
    input  logic [BGWIDTH-1:0]  bg,
    input  logic [BAWIDTH-1:0]  ba,
    input  logic [16:0]         A,
    output logic                dq_oe,
    output logic                dq_we,
    output logic [COLWIDTH-1:0] beat_col,
    output logic [RKW-1:0]      beat_rank,
    output logic [BGWIDTH-1:0]  beat_bg,
    output logic [BAWIDTH-1:0]  beat_ba,
    output logic                beat_last,
    output logic                dqs_t,
    output logic                ap_done,
    output logic                qfull,
    output logic                busy,
    output logic                cs_err,
    output logic                ovf_err,
    output logic                ovl_err
);

    localparam int LMAX = (CL > CWL) ? CL : CWL;
    localparam int CNTW = $clog2(LMAX);
    localparam int SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CNTW-1:0] RD_CNT = CNTW'(CL - 1);
    localparam logic [CNTW-1:0] WR_CNT = CNTW'(CWL - 1);

    typedef struct packed {
        logic                wr;
        logic                ap;
        logic                bl8;
        logic [RKW-1:0]      rank;
        logic [BGWIDTH-1:0]  bg;
        logic [BAWIDTH-1:0]  ba;
        logic [COLWIDTH-1:0] col;
        logic [CNTW-1:0]     cnt;
    } slot_t;

    function automatic logic [COLWIDTH-1:0] beat_col_f(
        input logic [COLWIDTH-1:0] c,
        input logic [2:0]          b,
        input logic                bl8
    );
        logic [COLWIDTH-1:0] r;
        r = c;
        if (bl8) r[2:0] = c[2:0] + b;
        else     r[1:0] = c[1:0] + b[1:0];
        return r;
    endfunction

    slot_t            slot_q [SLOTS];
    slot_t            slot_d [SLOTS];
    logic [SLOTS-1:0] vld_q, vld_d;

    // Command decode
    logic           cmd, cs_any, cs_multi, cs_one, cmd_bl8;
    logic [RKW-1:0] cmd_rank;
    slot_t          new_slot;
    logic           unused_a;

    assign unused_a = ^A;
    assign cmd      = RD | RDA | WR | WRA;
    assign cs_one   = cs_any & ~cs_multi;
    assign cmd_bl8  = (BURST_MODE == 0) ? 1'b1 :
                      (BURST_MODE == 1) ? 1'b0 : A[12];

    always_comb begin : cs_decode
        cs_any   = 1'b0;
        cs_multi = 1'b0;
        cmd_rank = '0;
        for (int r = 0; r < RANKS; r++) begin
            if (!cs_n[r]) begin
                if (cs_any) cs_multi = 1'b1;
                cs_any   = 1'b1;
                cmd_rank = RKW'(r);
            end
        end
    end

    always_comb begin : new_slot_build
        new_slot      = '0;
        new_slot.wr   = WR | WRA;
        new_slot.ap   = RDA | WRA;
        new_slot.bl8  = cmd_bl8;
        new_slot.rank = cmd_rank;
        new_slot.bg   = bg;
        new_slot.ba   = ba;
        new_slot.col  = A[COLWIDTH-1:0];
        new_slot.cnt  = (WR | WRA) ? WR_CNT : RD_CNT;
    end

    // Launch detection; reads beat writes, then lowest index
    logic [SLOTS-1:0] launch;
    logic             rd_found, any_found, multi_launch;
    logic [SW-1:0]    rd_idx, any_idx, win_idx;
    slot_t            win;

    always_comb begin : arb
        launch    = '0;
        rd_found  = 1'b0;
        any_found = 1'b0;
        rd_idx    = '0;
        any_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (vld_q[i] && slot_q[i].cnt == '0) begin
                launch[i] = 1'b1;
                if (!any_found) begin
                    any_found = 1'b1;
                    any_idx   = SW'(i);
                end
                if (!rd_found && !slot_q[i].wr) begin
                    rd_found = 1'b1;
                    rd_idx   = SW'(i);
                end
            end
        end
        win_idx      = rd_found ? rd_idx : any_idx;
        multi_launch = |(launch & (launch - SLOTS'(1)));
        win          = slot_q[win_idx];
    end

    // Slot pool update; a launching slot is free for this cycle's command
    logic          free_found;
    logic [SW-1:0] free_idx;
    logic          cs_err_d, ovf_err_d;

    always_comb begin : slot_next
        vld_d      = vld_q;
        slot_d     = slot_q;
        cs_err_d   = 1'b0;
        ovf_err_d  = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (vld_q[i]) begin
                if (launch[i]) vld_d[i] = 1'b0;
                else slot_d[i].cnt = slot_q[i].cnt - CNTW'(1);
            end
            if ((!vld_q[i] || launch[i]) && !free_found) begin
                free_found = 1'b1;
                free_idx   = SW'(i);
            end
        end
        if (cmd) begin
            if (cs_multi) begin
                cs_err_d = 1'b1;
            end else if (cs_one) begin
                if (free_found) begin
                    vld_d[free_idx]  = 1'b1;
                    slot_d[free_idx] = new_slot;
                end else begin
                    ovf_err_d = 1'b1;
                end
            end
        end
    end

    // Beat engine; output registers hold the current beat
    logic                in_prog, launch_ok;
    logic [2:0]          idx_q, idx_d;
    logic                len8_q, len8_d, ap_q, ap_d;
    logic [COLWIDTH-1:0] col_q, col_d;
    logic                oe_q, oe_d, we_q, we_d;
    logic [COLWIDTH-1:0] bcol_q, bcol_d;
    logic [RKW-1:0]      brank_q, brank_d;
    logic [BGWIDTH-1:0]  bbg_q, bbg_d;
    logic [BAWIDTH-1:0]  bba_q, bba_d;
    logic                last_q, last_d, dqs_q, dqs_d, apd_q, apd_d;
    logic                qfull_q, qfull_d, busy_q, busy_d;
    logic                cserr_q, ovf_q, ovl_q, ovl_d;

    always_comb begin : burst_next
        in_prog   = (oe_q | we_q) & ~last_q;
        launch_ok = any_found & ~in_prog;
        ovl_d     = any_found & (in_prog | multi_launch);
        oe_d      = 1'b0;
        we_d      = 1'b0;
        idx_d     = '0;
        len8_d    = 1'b0;
        ap_d      = 1'b0;
        col_d     = '0;
        bcol_d    = '0;
        brank_d   = '0;
        bbg_d     = '0;
        bba_d     = '0;
        unique case (1'b1)
            launch_ok: begin
                oe_d    = ~win.wr;
                we_d    = win.wr;
                len8_d  = win.bl8;
                ap_d    = win.ap;
                col_d   = win.col;
                bcol_d  = win.col;
                brank_d = win.rank;
                bbg_d   = win.bg;
                bba_d   = win.ba;
            end
            in_prog: begin
                oe_d    = oe_q;
                we_d    = we_q;
                idx_d   = idx_q + 3'd1;
                len8_d  = len8_q;
                ap_d    = ap_q;
                col_d   = col_q;
                bcol_d  = beat_col_f(col_q, idx_d, len8_q);
                brank_d = brank_q;
                bbg_d   = bbg_q;
                bba_d   = bba_q;
            end
            default: ;
        endcase
        last_d  = (oe_d | we_d) & (idx_d == (len8_d ? 3'd7 : 3'd3));
        apd_d   = last_d & ap_d;
        dqs_d   = (oe_d | we_d) & ~dqs_q;
        qfull_d = &vld_d;
        busy_d  = (|vld_d) | oe_d | we_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
            idx_q   <= '0;
            len8_q  <= 1'b0;
            ap_q    <= 1'b0;
            col_q   <= '0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            bcol_q  <= '0;
            brank_q <= '0;
            bbg_q   <= '0;
            bba_q   <= '0;
            last_q  <= 1'b0;
            dqs_q   <= 1'b0;
            apd_q   <= 1'b0;
            qfull_q <= 1'b0;
            busy_q  <= 1'b0;
            cserr_q <= 1'b0;
            ovf_q   <= 1'b0;
            ovl_q   <= 1'b0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= slot_d[i];
            idx_q   <= idx_d;
            len8_q  <= len8_d;
            ap_q    <= ap_d;
            col_q   <= col_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            bcol_q  <= bcol_d;
            brank_q <= brank_d;
            bbg_q   <= bbg_d;
            bba_q   <= bba_d;
            last_q  <= last_d;
            dqs_q   <= dqs_d;
            apd_q   <= apd_d;
            qfull_q <= qfull_d;
            busy_q  <= busy_d;
            cserr_q <= cs_err_d;
            ovf_q   <= ovf_err_d;
            ovl_q   <= ovl_d;
        end
    end

    assign dq_oe     = oe_q;
    assign dq_we     = we_q;
    assign beat_col  = bcol_q;
    assign beat_rank = brank_q;
    assign beat_bg   = bbg_q;
    assign beat_ba   = bba_q;
    assign beat_last = last_q;
    assign dqs_t     = dqs_q;
    assign ap_done   = apd_q;
    assign qfull     = qfull_q;
    assign busy      = busy_q;
    assign cs_err    = cserr_q;
    assign ovf_err   = ovf_q;
    assign ovl_err   = ovl_q;

endmodule

// File: tb/tb_dimm_burst_sequencer.sv
// tb_dimm_burst_sequencer: directed and random commands checked against
// a time-stamped command/burst model of the sequencer.
module tb_dimm_burst_sequencer;

    localparam int RANKS = 2;
    localparam int CL    = 5;
    localparam int CWL   = 4;
    localparam int SLOTS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RD = 0, RDA = 0, WR = 0, WRA = 0;
    logic [1:0]  cs_n = 2'b11;
    logic [1:0]  bg = 0, ba = 0;
    logic [16:0] A = 0;
    logic        dq_oe, dq_we, beat_last, dqs_t, ap_done;
    logic        qfull, busy, cs_err, ovf_err, ovl_err;
    logic [9:0]  beat_col;
    logic [0:0]  beat_rank;
    logic [1:0]  beat_bg, beat_ba;

    dimm_burst_sequencer #(
        .RANKS(RANKS), .BGWIDTH(2), .BAWIDTH(2), .COLWIDTH(10),
        .CL(CL), .CWL(CWL), .BURST_MODE(2), .SLOTS(SLOTS)
    ) dut (
        .clk(clk), .reset(reset),
        .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA),
        .cs_n(cs_n), .bg(bg), .ba(ba), .A(A),
        .dq_oe(dq_oe), .dq_we(dq_we), .beat_col(beat_col),
        .beat_rank(beat_rank), .beat_bg(beat_bg), .beat_ba(beat_ba),
        .beat_last(beat_last), .dqs_t(dqs_t), .ap_done(ap_done),
        .qfull(qfull), .busy(busy), .cs_err(cs_err),
        .ovf_err(ovf_err), .ovl_err(ovl_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        int launch;
        bit wr;
        bit ap;
        bit bl8;
        int rank;
        int bg;
        int ba;
        int col;
    } cmd_t;

    cmd_t pend[$];
    cmd_t cur;
    int   b_start = 0;
    int   b_end = -1;
    int   cyc = 0;
    bit   prev_dqs = 0;
    bit   e_oe, e_we, e_last, e_dqs, e_ap, e_qfull, e_busy;
    bit   e_cserr, e_ovf, e_ovl;
    int   e_col, e_rank, e_bg, e_ba;
    int   obs_cols[$];
    int   ap_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
                   tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        pend.delete();
        b_start = 0;
        b_end = -1;
        cyc = 0;
        prev_dqs = 0;
        {e_oe, e_we, e_last, e_dqs, e_ap, e_qfull, e_busy} = '0;
        {e_cserr, e_ovf, e_ovl} = '0;
        e_col = 0;
        e_rank = 0;
        e_bg = 0;
        e_ba = 0;
    endfunction

    // One clock edge of the reference behaviour, in absolute time
    task automatic model_step(input bit rd, rda, wr, wra,
                              input logic [1:0] csn,
                              input logic [1:0] vbg, vba,
                              input logic [16:0] a);
        cmd_t lq[$];
        cmd_t nc;
        int   i, nlow, b, m;
        bit   inprog, act, anycmd;
        cyc++;
        i = 0;
        while (i < pend.size()) begin
            if (pend[i].launch == cyc) begin
                lq.push_back(pend[i]);
                pend.delete(i);
            end else begin
                i++;
            end
        end
        inprog = (b_end >= cyc);
        e_ovl = (lq.size() > 0) && (inprog || lq.size() > 1);
        if (lq.size() > 0 && !inprog) begin
            cur = lq[0];
            foreach (lq[k]) if (!lq[k].wr) cur = lq[k];
            b_start = cyc;
            b_end = cyc + (cur.bl8 ? 8 : 4) - 1;
        end
        anycmd = rd | rda | wr | wra;
        nlow = int'(csn[0] == 1'b0) + int'(csn[1] == 1'b0);
        e_cserr = anycmd && nlow > 1;
        e_ovf = 0;
        if (anycmd && nlow == 1) begin
            if (pend.size() < SLOTS) begin
                nc.wr = wr | wra;
                nc.ap = rda | wra;
                nc.bl8 = a[12];
                nc.rank = (csn[0] == 1'b0) ? 0 : 1;
                nc.bg = int'(vbg);
                nc.ba = int'(vba);
                nc.col = int'(a[9:0]);
                nc.launch = cyc + (nc.wr ? CWL : CL);
                pend.push_back(nc);
            end else begin
                e_ovf = 1;
            end
        end
        act = (b_start <= cyc) && (cyc <= b_end);
        if (act) begin
            b = cyc - b_start;
            m = cur.bl8 ? 8 : 4;
            e_oe = !cur.wr;
            e_we = cur.wr;
            e_col = cur.col - (cur.col % m) + ((cur.col % m) + b) % m;
            e_rank = cur.rank;
            e_bg = cur.bg;
            e_ba = cur.ba;
            e_last = (cyc == b_end);
            e_ap = e_last && cur.ap;
            e_dqs = !prev_dqs;
        end else begin
            {e_oe, e_we, e_last, e_ap, e_dqs} = '0;
        end
        prev_dqs = e_dqs;
        e_qfull = (pend.size() == SLOTS);
        e_busy = (pend.size() > 0) || act;
    endtask

    task automatic check_all();
        chk("dq_oe", 32'(dq_oe), 32'(e_oe));
        chk("dq_we", 32'(dq_we), 32'(e_we));
        chk("beat_last", 32'(beat_last), 32'(e_last));
        chk("dqs_t", 32'(dqs_t), 32'(e_dqs));
        chk("ap_done", 32'(ap_done), 32'(e_ap));
        chk("qfull", 32'(qfull), 32'(e_qfull));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("cs_err", 32'(cs_err), 32'(e_cserr));
        chk("ovf_err", 32'(ovf_err), 32'(e_ovf));
        chk("ovl_err", 32'(ovl_err), 32'(e_ovl));
        if (e_oe || e_we) begin
            chk("beat_col", 32'(beat_col), 32'(e_col));
            chk("beat_rank", 32'(beat_rank), 32'(e_rank));
            chk("beat_bg", 32'(beat_bg), 32'(e_bg));
            chk("beat_ba", 32'(beat_ba), 32'(e_ba));
        end
        if (dq_oe || dq_we) obs_cols.push_back(int'(beat_col));
        if (ap_done) ap_seen++;
    endtask

    task automatic cycle(input bit rd, rda, wr, wra,
                         input logic [1:0] csn,
                         input logic [1:0] vbg, vba,
                         input logic [16:0] a);
        RD = rd;
        RDA = rda;
        WR = wr;
        WRA = wra;
        cs_n = csn;
        bg = vbg;
        ba = vba;
        A = a;
        @(posedge clk);
        model_step(rd, rda, wr, wra, csn, vbg, vba, a);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(0, 0, 0, 0, 2'b11, 2'd0, 2'd0, 17'd0);
    endtask

    task automatic do_reset();
        {RD, RDA, WR, WRA} = '0;
        cs_n = 2'b11;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_col", 32'(beat_col), 32'd0);
        chk("rst_rank", 32'(beat_rank), 32'd0);
        chk("rst_bgba", 32'({beat_bg, beat_ba}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
    endtask

    function automatic logic [16:0] mkA(input int col, input bit a12);
        logic [16:0] a;
        a = '0;
        a[9:0] = col[9:0];
        a[12] = a12;
        return a;
    endfunction

    int exp_bl8[8] = '{13, 14, 15, 8, 9, 10, 11, 12};
    int exp_bc4[4] = '{6, 7, 4, 5};

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // BL8 read, column wraps inside its 8-aligned block
        obs_cols.delete();
        cycle(1, 0, 0, 0, 2'b10, 2'd0, 2'd0, mkA('h00D, 1));
        idle(14);
        chk("bl8_len", 32'(obs_cols.size()), 32'd8);
        for (int i = 0; i < 8 && i < obs_cols.size(); i++)
            chk("bl8_col", 32'(obs_cols[i]), 32'(exp_bl8[i]));

        // BC4 write with auto-precharge
        obs_cols.delete();
        ap_seen = 0;
        cycle(0, 0, 0, 1, 2'b10, 2'd2, 2'd1, mkA('h006, 0));
        idle(10);
        chk("bc4_len", 32'(obs_cols.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_cols.size(); i++)
            chk("bc4_col", 32'(obs_cols[i]), 32'(exp_bc4[i]));
        chk("ap_count", 32'(ap_seen), 32'd1);

        // Rank select errors and rank index
        obs_cols.delete();
        cycle(1, 0, 0, 0, 2'b00, 2'd0, 2'd0, mkA(0, 1));
        idle(8);
        chk("cs_err_noburst", 32'(obs_cols.size()), 32'd0);
        cycle(1, 0, 0, 0, 2'b01, 2'd1, 2'd3, mkA('h123, 1));
        idle(14);

        // Slot overflow and launch overlap
        cycle(1, 0, 0, 0, 2'b10, 2'd0, 2'd0, mkA(1, 1));
        cycle(1, 0, 0, 0, 2'b10, 2'd1, 2'd0, mkA(2, 1));
        cycle(1, 0, 0, 0, 2'b10, 2'd2, 2'd0, mkA(3, 1));
        idle(20);

        // Read and write launching on the same edge
        cycle(1, 0, 0, 0, 2'b10, 2'd0, 2'd0, mkA(4, 1));
        cycle(0, 0, 1, 0, 2'b10, 2'd3, 2'd3, mkA(5, 1));
        idle(15);

        // Back-to-back bursts, then a clean run and a mid-burst reset
        obs_cols.delete();
        cycle(1, 0, 0, 0, 2'b10, 2'd0, 2'd0, mkA('h010, 1));
        idle(7);
        cycle(1, 0, 0, 0, 2'b10, 2'd1, 2'd1, mkA('h020, 1));
        idle(20);
        chk("b2b_beats", 32'(obs_cols.size()), 32'd16);
        cycle(1, 0, 0, 0, 2'b10, 2'd0, 2'd0, mkA('h030, 1));
        idle(7);
        cycle(0, 1, 0, 0, 2'b10, 2'd1, 2'd1, mkA('h040, 1));
        idle(1);
        do_reset();
        ap_seen = 0;
        idle(12);
        chk("no_ap_after_rst", 32'(ap_seen), 32'd0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            if ($urandom_range(0, 2) == 0) begin
                logic [1:0] t;
                t = 2'($urandom_range(0, 3));
                cycle(t == 0, t == 1, t == 2, t == 3,
                      2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)),
                      17'($urandom()));
            end else begin
                idle(1);
            end
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dimm_burst_sequencer.md
# dimm_burst_sequencer

Parametrised data-phase sequencer for the DIMM emulator. It sits between the command decoder and the per-chip data path. It accepts decoded read and write column commands from any rank and schedules each burst at CL or CWL. Each data beat is then driven as a per-cycle column, rank, bank and direction strobe. Over the fixed single-rank BL8 path it adds multi-rank selection, burst-chop modes, a pending-command slot pool, auto-precharge completion pulses and error flags.

## Interface
Parameters:
- RANKS, 1, number of ranks (one cs_n bit each)
- BGWIDTH, 2, bankgroup address width
- BAWIDTH, 2, bank address width
- COLWIDTH, 10, column address width (≥3)
- CL, 5, read latency in clk cycles (≥2)
- CWL, 4, write latency in clk cycles (≥2)
- BURST_MODE, 0, 0 = fixed BL8, 1 = fixed BC4, 2 = on-the-fly (A12 high = BL8, A12 low = BC4)
- SLOTS, 4, pending-command slots (≥2)
- RKW (local), max(1,$clog2(RANKS))

Ports:
- clk  in  1  emulation clock (ck_t gated by cke upstream)
- reset  in  1  asynchronous, active-high
- RD, RDA, WR, WRA  in  1 each  decoded command pulses, one-hot, sampled every clk
- cs_n  in  RANKS  active-low rank select
- bg  in  BGWIDTH  bankgroup
- ba  in  BAWIDTH  bank
- A  in  17  address pins; A[COLWIDTH-1:0] column, A[12] burst chop
- dq_oe  out  1  read beat active (drive dq/dqs)
- dq_we  out  1  write beat active (capture dq)
- beat_col  out  COLWIDTH  column of current beat
- beat_rank  out  RKW  rank index of current beat
- beat_bg / beat_ba  out  BGWIDTH / BAWIDTH  bank of current beat
- beat_last  out  1  final beat of burst
- dqs_t  out  1  toggles every beat, low when idle
- ap_done  out  1  one-cycle pulse on last beat of RDA/WRA burst (with beat_bg/ba/rank valid)
- qfull  out  1  all slots occupied
- busy  out  1  any slot occupied or burst in progress
- cs_err, ovf_err, ovl_err  out  1 each  one-cycle error pulses

## Operation
- Command accept: any of RD/RDA/WR/WRA high, and exactly one cs_n bit low. The rank index is the position of the low bit.
- Zero cs_n low: ignored silently. More than one low: cs_err pulse, command dropped.
- An accepted command is loaded into the lowest free slot. The slot holds:
  - dir, ap, rank, bg, ba, column, burst length
  - countdown = latency−1 (CL−1 for reads, CWL−1 for writes)
- Burst length follows BURST_MODE: 8 or 4.
- No free slot: ovf_err pulse, command dropped. A command arriving in the same cycle a slot frees is accepted.
- Each cycle, every occupied slot with a nonzero countdown decrements. A slot reaching zero launches its burst and frees the slot.
- Launch conflicts, in order of precedence:
  - Burst already in progress: launching slot dropped, ovl_err pulse.
  - Two slots launch in the same cycle: the read wins; otherwise the lower slot index wins. The loser is dropped with ovl_err.
- Beat column, for beat index b:
  - BL8: {col[COLWIDTH-1:3], (col[2:0]+b) mod 8}
  - BC4: {col[COLWIDTH-1:2], (col[1:0]+b) mod 4}
- dq_oe (reads) or dq_we (writes) is high for exactly 8 or 4 consecutive cycles. beat_last is high on the final beat. ap_done accompanies beat_last when ap is set.
- Back-to-back bursts: a launch on the cycle after beat_last continues seamlessly, with no idle cycle and dqs_t continuing to toggle.

## Timing
- Command sampled at posedge T; first beat outputs are registered and valid after posedge T+L (L = CL or CWL).
- All outputs are registered.
- Reset values: every output 0; all slots free; dqs_t 0.
- dqs_t inverts on each beat and returns to 0 on the first idle cycle.
- Error pulses are asserted for the cycle after the offending posedge.
- qfull and busy reflect slot state after the posedge.
- Reset asserted mid-burst: beats stop immediately, queued commands are discarded, no ap_done is issued.

## Test plan
- CL=5, BURST_MODE=0: RD with cs_n=1'b0 and col 0x00D at T → dq_oe for T+5..T+12, beat_col 0x00D,0x00E,0x00F,0x008..0x00C, beat_last at T+12.
- BURST_MODE=2: WRA with A12=0, col 0x006, bg=2, ba=1 at T (CWL=4) → dq_we T+4..T+7, cols 0x006,0x007,0x004,0x005, ap_done at T+7 with bg=2, ba=1.
- RANKS=2: RD with cs_n=2'b00 → cs_err, no burst. RD with cs_n=2'b01 → beat_rank=1.
- SLOTS=2, CL=8: three RDs on consecutive cycles → third gives ovf_err. Bursts 1–2 overlap, so burst 2 gets ovl_err and burst 1 completes.
- RD at T and WR at T+1 (CL=5, CWL=4) → both launch at T+5; read runs 8 beats, write is dropped with ovl_err.
- RD at T and RD at T+8 (CL=5) → 16 contiguous dq_oe beats, dqs_t toggling throughout. Assert reset at T+9 → all outputs 0 next cycle, busy=0.
